// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between I-cache block refills and single-beat D-side loads/stores.
// Latency: request issued the cycle after arbitration; refill beats and D completion are registered one cycle.
// Backpressure: requests are held until mem_ack_i and I bursts are never preempted. ARB_DATA_PRIORITY_EN selects fixed D priority.
module mem_port_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ic_miss_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              rep_ready_o,
  output logic [63:0]       rep_word_o,
  output logic              ic_done_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [31:0]       dm_wdata_i,
  output logic [31:0]       dm_rdata_o,
  output logic              dm_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_len_o,
  output logic [63:0]       mem_wdata_o,
  output logic [7:0]        mem_wstrb_o,
  input  logic              mem_ack_i,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_REQ   = 3'd1,
    I_BURST = 3'd2,
    D_REQ   = 3'd3,
    D_WAIT  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic             ic_vld, dm_vld, grant_d;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^dm_addr_i[1:0];

  // A requester still holds its line during its own done pulse; that is not a new request.
  assign ic_vld = ic_miss_i & ~ic_done_o;
  assign dm_vld = dm_req_i & ~dm_done_o;

`ifdef ARB_DATA_PRIORITY_EN
  assign grant_d = dm_vld;
`else
  logic last_grant_i;

  assign grant_d = dm_vld & (~ic_vld | last_grant_i);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      last_grant_i <= 1'b0;
    end else if (state == I_BURST && mem_rvalid_i && beat_cnt == LAST_BEAT) begin
      last_grant_i <= 1'b1;
    end else if ((state == D_REQ && mem_ack_i && dm_we_i) || (state == D_WAIT && mem_rvalid_i)) begin
      last_grant_i <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)     state_nxt = D_REQ;
        else if (ic_vld) state_nxt = I_REQ;
      end
      I_REQ:   if (mem_ack_i) state_nxt = I_BURST;
      I_BURST: if (mem_rvalid_i && beat_cnt == LAST_BEAT) state_nxt = IDLE;
      D_REQ:   if (mem_ack_i) state_nxt = dm_we_i ? IDLE : D_WAIT;
      D_WAIT:  if (mem_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields follow the held requester inputs and are zero outside a request state.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_len_o   = 8'd0;
    mem_wdata_o = 64'd0;
    mem_wstrb_o = 8'h00;
    if (state == I_REQ) begin
      mem_req_o  = 1'b1;
      mem_addr_o = ic_addr_i;
      mem_len_o  = 8'(BLOCK_WORDS);
    end else if (state == D_REQ) begin
      mem_req_o   = 1'b1;
      mem_we_o    = dm_we_i;
      mem_addr_o  = {dm_addr_i[ADDR_W-1:3], 3'b000};
      mem_len_o   = 8'd1;
      mem_wdata_o = {dm_wdata_i, dm_wdata_i};
      mem_wstrb_o = dm_addr_i[2] ? 8'hF0 : 8'h0F;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rep_ready_o <= 1'b0;
      rep_word_o  <= 64'd0;
      ic_done_o   <= 1'b0;
      dm_rdata_o  <= 32'd0;
      dm_done_o   <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      rep_ready_o <= 1'b0;
      ic_done_o   <= 1'b0;
      dm_done_o   <= 1'b0;
      case (state)
        I_REQ: if (mem_ack_i) beat_cnt <= '0;
        I_BURST: begin
          if (mem_rvalid_i) begin
            rep_word_o  <= mem_rdata_i;
            rep_ready_o <= 1'b1;
            beat_cnt    <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) ic_done_o <= 1'b1;
          end
        end
        D_REQ: if (mem_ack_i && dm_we_i) dm_done_o <= 1'b1;
        D_WAIT: begin
          if (mem_rvalid_i) begin
            dm_rdata_o <= dm_addr_i[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
            dm_done_o  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: D-side vector table plus refill, tie, mid-burst and reset sequences.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ic_miss_i, dm_req_i, dm_we_i;
  logic [31:0] ic_addr_i, dm_addr_i, dm_wdata_i;
  logic        rep_ready_o, ic_done_o, dm_done_o;
  logic [63:0] rep_word_o, mem_wdata_o, mem_rdata_i;
  logic [31:0] dm_rdata_o, mem_addr_o;
  logic        mem_req_o, mem_we_o, mem_ack_i, mem_rvalid_i;
  logic [7:0]  mem_len_o, mem_wstrb_o;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.BLOCK_WORDS(4), .ADDR_W(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i),
    .rep_ready_o(rep_ready_o), .rep_word_o(rep_word_o), .ic_done_o(ic_done_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_done_o(dm_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_len_o(mem_len_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ack_i(mem_ack_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] rdata;
    logic [31:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [31:0] exp_rdata;
  } dvec_t;

  dvec_t vec[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Entered on the falling edge where the I request is on the port.
  task automatic i_burst(input string tag, input logic [31:0] exp_addr, input logic [63:0] w0,
                         input int raise_d_at);
    chk({tag, "_req"},  {63'd0, mem_req_o}, 64'd1);
    chk({tag, "_len"},  {56'd0, mem_len_o}, 64'd4);
    chk({tag, "_addr"}, {32'd0, mem_addr_o}, {32'd0, exp_addr});
    chk({tag, "_we"},   {63'd0, mem_we_o}, 64'd0);
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == raise_d_at) dm_req_i = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = w0 + 64'(b);
      @(negedge clk_i);
      chk({tag, "_rep_ready"}, {63'd0, rep_ready_o}, 64'd1);
      chk({tag, "_rep_word"},  rep_word_o, w0 + 64'(b));
      chk({tag, "_ic_done"},   {63'd0, ic_done_o}, (b == 3) ? 64'd1 : 64'd0);
      chk({tag, "_no_preempt"}, {63'd0, mem_req_o}, 64'd0);
    end
    mem_rvalid_i = 1'b0;
    ic_miss_i    = 1'b0;
  endtask

  // Entered on the falling edge where the D request is on the port.
  task automatic d_finish(input string tag, input dvec_t v);
    chk({tag, "_req"},   {63'd0, mem_req_o}, 64'd1);
    chk({tag, "_len"},   {56'd0, mem_len_o}, 64'd1);
    chk({tag, "_we"},    {63'd0, mem_we_o}, {63'd0, v.we});
    chk({tag, "_addr"},  {32'd0, mem_addr_o}, {32'd0, v.exp_addr});
    chk({tag, "_strb"},  {56'd0, mem_wstrb_o}, {56'd0, v.exp_strb});
    chk({tag, "_wdata"}, mem_wdata_o, v.exp_wdata);
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    if (v.we) begin
      chk({tag, "_st_done"}, {63'd0, dm_done_o}, 64'd1);
    end else begin
      chk({tag, "_ld_wait"}, {63'd0, dm_done_o}, 64'd0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = v.rdata;
      @(negedge clk_i);
      mem_rvalid_i = 1'b0;
      chk({tag, "_ld_done"},  {63'd0, dm_done_o}, 64'd1);
      chk({tag, "_ld_rdata"}, {32'd0, dm_rdata_o}, {32'd0, v.exp_rdata});
    end
    dm_req_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_done_pulse"}, {63'd0, dm_done_o}, 64'd0);
    chk({tag, "_idle"},       {63'd0, mem_req_o}, 64'd0);
  endtask

  task automatic set_d(input dvec_t v);
    dm_we_i    = v.we;
    dm_addr_i  = v.addr;
    dm_wdata_i = v.wdata;
  endtask

  initial begin
    vec[0] = '{we: 1'b1, addr: 32'h64, wdata: 32'd25, rdata: 64'd0,
               exp_addr: 32'h60, exp_strb: 8'hF0, exp_wdata: {2{32'd25}}, exp_rdata: 32'd0};
    vec[1] = '{we: 1'b0, addr: 32'h60, wdata: 32'h5555_AAAA, rdata: 64'h1111_2222_3333_4444,
               exp_addr: 32'h60, exp_strb: 8'h0F, exp_wdata: 64'h5555_AAAA_5555_AAAA, exp_rdata: 32'h3333_4444};
    vec[2] = '{we: 1'b0, addr: 32'h6C, wdata: 32'd0, rdata: 64'hDEAD_BEEF_0123_4567,
               exp_addr: 32'h68, exp_strb: 8'hF0, exp_wdata: 64'd0, exp_rdata: 32'hDEAD_BEEF};
    vec[3] = '{we: 1'b1, addr: 32'h1000, wdata: 32'hCAFE_F00D, rdata: 64'd0,
               exp_addr: 32'h1000, exp_strb: 8'h0F, exp_wdata: {2{32'hCAFE_F00D}}, exp_rdata: 32'd0};

    reset_i = 1'b0;
    ic_miss_i = 1'b0; ic_addr_i = 32'd0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'd0; dm_wdata_i = 32'd0;
    mem_ack_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_mem_req",   {63'd0, mem_req_o}, 64'd0);
    chk("rst_rep_ready", {63'd0, rep_ready_o}, 64'd0);
    chk("rst_rep_word",  rep_word_o, 64'd0);
    chk("rst_dm_done",   {63'd0, dm_done_o}, 64'd0);
    chk("rst_dm_rdata",  {32'd0, dm_rdata_o}, 64'd0);
    chk("rst_mem_len",   {56'd0, mem_len_o}, 64'd0);
    reset_i = 1'b1;
    @(negedge clk_i);

    // Tie right after reset: I wins, D follows immediately after ic_done_o.
    ic_miss_i = 1'b1; ic_addr_i = 32'h100;
    set_d(vec[0]); dm_req_i = 1'b1;
    @(negedge clk_i);
    i_burst("tie1_i", 32'h100, 64'hA, -1);
    @(negedge clk_i);
    d_finish("tie1_d", vec[0]);

    // Second tie: last grant was D, so I again.
    ic_miss_i = 1'b1; ic_addr_i = 32'h200;
    set_d(vec[1]); dm_req_i = 1'b1;
    @(negedge clk_i);
    i_burst("tie2_i", 32'h200, 64'h20, -1);
    @(negedge clk_i);
    d_finish("tie2_d", vec[1]);

    // Stray handshakes in IDLE are ignored.
    mem_rvalid_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 64'hFFFF;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_ack_i = 1'b0;
    chk("idle_stray_rep", {63'd0, rep_ready_o}, 64'd0);
    chk("idle_stray_dm",  {63'd0, dm_done_o}, 64'd0);
    chk("idle_stray_req", {63'd0, mem_req_o}, 64'd0);

    for (int i = 0; i < 4; i++) begin
      set_d(vec[i]); dm_req_i = 1'b1;
      @(negedge clk_i);
      d_finish($sformatf("vec%0d", i), vec[i]);
    end

    // Plain refill, D request rising mid-burst.
    ic_miss_i = 1'b1; ic_addr_i = 32'h100;
    set_d(vec[3]);
    @(negedge clk_i);
    i_burst("mid_i", 32'h100, 64'hA, 2);
    @(negedge clk_i);
    d_finish("mid_d", vec[3]);

    // Reset after the second beat.
    ic_miss_i = 1'b1; ic_addr_i = 32'h300;
    @(negedge clk_i);
    chk("rst_burst_req", {63'd0, mem_req_o}, 64'd1);
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 64'h300 + 64'(b);
      @(negedge clk_i);
    end
    mem_rvalid_i = 1'b0;
    chk("rst_burst_beat2", rep_word_o, 64'h301);
    #2 reset_i = 1'b0;
    #1;
    chk("async_rst_rep_ready", {63'd0, rep_ready_o}, 64'd0);
    chk("async_rst_rep_word",  rep_word_o, 64'd0);
    chk("async_rst_mem_req",   {63'd0, mem_req_o}, 64'd0);
    ic_miss_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h302;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    chk("post_rst_stray_rep", {63'd0, rep_ready_o}, 64'd0);
    chk("post_rst_stray_done", {63'd0, ic_done_o}, 64'd0);
    chk("post_rst_idle", {63'd0, mem_req_o}, 64'd0);

    // Refill works normally after the aborted burst.
    ic_miss_i = 1'b1; ic_addr_i = 32'h400;
    @(negedge clk_i);
    i_burst("post_rst_i", 32'h400, 64'h40, -1);
    @(negedge clk_i);
    chk("post_rst_final_idle", {63'd0, mem_req_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
